ray_strip_worker: RTL and testbench
===================================

RAY_STRIP_WORKER -- requirements
Module: ray_strip_worker

Interface
REQ-001 Parameter N_SPHERES, default 4: number of spheres tested per pixel (1..16).
REQ-002 Parameter STRIP_LEN, default 64: pixels rendered per job.
REQ-003 Parameter PX_STRIDE, default 10: x-step between consecutive pixels of a strip (the worker count).
REQ-004 Parameter PZ, default 320: constant ray-direction z component.
REQ-005 Parameter CW, default 16: signed width of sphere centre coordinates; radius is unsigned CW-1 bits.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 Port clk  in  1  rising-edge clock.
REQ-008 Port rst  in  1  synchronous active-high reset.
REQ-009 Port start  in  1  one-cycle job request; accepted only while busy=0.
REQ-010 Port pixel_start_x  in  12 signed  x of the first pixel of the strip.
REQ-011 Port pixel_y  in  12 signed  row y; sampled at start.
REQ-012 Port spheres  in  N_SPHERES x Types::Sphere  centre x/y/z, radius r, color; sampled at start.
REQ-013 Port busy  out  1  high from the cycle after an accepted start until the done cycle.
REQ-014 Port done  out  1  one-cycle pulse after the last pixel write.
REQ-015 Port wr_en  out  1  one-cycle pixel write strobe.
REQ-016 Port wr_addr  out  clog2(STRIP_LEN)  pixel index within the strip.
REQ-017 Port wr_color  out  Types::Color  pixel color.

Function
REQ-018 Pixel k (0..STRIP_LEN-1) uses ray d=(pixel_start_x+k*PX_STRIDE, pixel_y, PZ) from the origin.
REQ-019 Per sphere: a=d.d, b=2(d.s), c=s.s-r^2, dis=b^2-4ac; all products are full-width signed, with no truncation for full-range inputs.
REQ-020 Hit: dis>=0 and num=b-isqrt(dis)>0; a sphere behind the eye is never a hit.
REQ-021 Nearest hit per pixel: smallest num (a is common to all spheres of a pixel); on ties the lower sphere index wins.
REQ-022 wr_color = color of the nearest hit, else `BACKGROUND_COLOR.
REQ-023 FSM states: IDLE, SETUP, PRODUCTS, QUAD, SQRT_WAIT, COMPARE, WRITE, DONE.
REQ-024 IDLE->SETUP on start; latch inputs; clear pixel index, sphere index and best register (invalid).
REQ-025 SETUP computes d and a, then goes to PRODUCTS; PRODUCTS computes b and c; QUAD computes dis and pulses sqrt start.
REQ-026 SQRT_WAIT holds until the sqrt valid signal; COMPARE updates best; next sphere goes to PRODUCTS, last sphere goes to WRITE.
REQ-027 WRITE asserts wr_en for exactly one cycle; next pixel goes to SETUP, last pixel goes to DONE; DONE pulses done and returns to IDLE.
REQ-028 Per-sphere latency is exactly 4 + SQRT_CYC cycles; per-pixel latency is N_SPHERES*(4+SQRT_CYC)+2; both are constant and data-independent.
REQ-029 When dis<0, the sqrt is still run and the result is ignored, so timing stays fixed.
REQ-030 A start while busy=1 is ignored; a start in the DONE cycle is ignored.
REQ-031 wr_addr wraps to 0 only at the next job, never within a job.

Reset
REQ-032 rst returns the FSM to IDLE at the next edge in any state, aborting the job with no further wr_en.
REQ-033 Reset values: busy=0, done=0, wr_en=0, wr_addr=0, wr_color=0; the sqrt sub-module is also reset.

Structure
REQ-034 Types package holds Sphere, Color, `BACKGROUND_COLOR and the derived width constants (A_W, B_W, C_W, DIS_W).
REQ-035 One sub-module: isqrt, a restoring bit-serial integer square root of DIS_W bits. It takes SQRT_CYC=DIS_W/2 cycles from start to a one-cycle valid, giving floor(sqrt).

Verification
REQ-036 pixel (0,0), sphere (0,0,640) r=64 -> dis=1677721600, isqrt=40960, num=368640; hit, sphere color written.
REQ-037 pixel (0,0), sphere (1000,0,640) r=64 -> dis<0; `BACKGROUND_COLOR written.
REQ-038 Spheres (0,0,1280) r=64 at index 0 and (0,0,640) r=64 at index 1 -> the index-1 color wins; swapped order gives the same color; identical spheres -> index 0 color.
REQ-039 Sphere (0,0,-640) r=64 -> num<0; background written.
REQ-040 Full job, STRIP_LEN=64 -> exactly 64 wr_en pulses, addr 0..63 in order, then done; busy high for 64*(N_SPHERES*(4+SQRT_CYC)+2)+1 cycles; start during busy ignored.
REQ-041 rst asserted at pixel 17 in SQRT_WAIT -> busy=0 next cycle, no further wr_en; a new start then restarts at wr_addr 0.

Source files
------------

// File: rtl/ray_strip_worker_pkg.sv
// Shared types and derived datapath widths for the ray strip worker.
// Widths are sized so that no intermediate product truncates for full-range inputs.
package ray_strip_worker_pkg;

  localparam int CW      = 16;
  localparam int COLOR_W = 24;
  localparam int D_W     = 14;
  localparam int A_W     = 2 * D_W + 2;
  localparam int B_W     = D_W + CW + 3;
  localparam int C_W     = 2 * CW + 2;
  localparam int DIS_W   = 2 * B_W;
  localparam int ROOT_W  = DIS_W / 2;
  localparam int NUM_W   = B_W + 2;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic signed [CW-1:0] z;
    logic        [CW-2:0] r;
    color_t               color;
  } sphere_t;

  localparam color_t BACKGROUND_COLOR = 24'h203040;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PRODUCTS,
    QUAD,
    SQRT_WAIT,
    COMPARE,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/ray_strip_worker_isqrt.sv
// Restoring bit-serial integer square root: two radicand bits per cycle, W/2 iterations,
// then a one-cycle vld_o with root_o = floor(sqrt(op_i)) held until the next start.
module ray_strip_worker_isqrt #(
  parameter int W = 66
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   op_i,
  output logic           vld_o,
  output logic [W/2-1:0] root_o
);

  localparam int RW    = W / 2;
  localparam int CNT_W = $clog2(RW + 1);

  logic [W-1:0]     rad_q, rad_d;
  logic [RW+1:0]    rem_q, rem_d;
  logic [RW-1:0]    root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             vld_q, vld_d;
  logic [RW+3:0]    rem_sh, trial;

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    vld_d  = 1'b0;
    rem_sh = {rem_q, rad_q[W-1 -: 2]};
    trial  = {2'b00, root_q, 2'b01};
    if (start_i) begin
      rad_d  = op_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      rad_d = {rad_q[W-3:0], 2'b00};
      if (rem_sh >= trial) begin
        rem_d  = (RW + 2)'(rem_sh - trial);
        root_d = {root_q[RW-2:0], 1'b1};
      end else begin
        rem_d  = (RW + 2)'(rem_sh);
        root_d = {root_q[RW-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(RW - 1)) begin
        run_d = 1'b0;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      vld_q  <= vld_d;
    end
  end

  assign vld_o  = vld_q;
  assign root_o = root_q;

endmodule

// File: rtl/ray_strip_worker.sv
// Renders one strip of pixels by ray/sphere intersection, nearest hit per pixel.
// Fixed, data-independent timing: each sphere costs 4 + sqrt cycles, each pixel adds setup and write.
module ray_strip_worker
  import ray_strip_worker_pkg::*;
#(
  parameter int N_SPHERES = 4,
  parameter int STRIP_LEN = 64,
  parameter int PX_STRIDE = 10,
  parameter int PZ        = 320,
  parameter int CW        = 16,
  localparam int AW       = $clog2(STRIP_LEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [11:0]            pixel_start_x,
  input  logic signed [11:0]            pixel_y,
  input  sphere_t     [N_SPHERES-1:0]   spheres,
  output logic                          busy,
  output logic                          done,
  output logic                          wr_en,
  output logic        [AW-1:0]          wr_addr,
  output color_t                        wr_color
);

  localparam int SIDX_W = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
  localparam logic signed [D_W-1:0] DZ = D_W'(PZ);

  state_e                      state_q, state_d;
  sphere_t [N_SPHERES-1:0]     sph_q, sph_d;
  logic signed [D_W-1:0]       x_q, x_d, y_q, y_d;
  logic [AW-1:0]               pix_q, pix_d;
  logic [SIDX_W-1:0]           sidx_q, sidx_d;
  logic signed [A_W-1:0]       a_q, a_d;
  logic signed [B_W-1:0]       b_q, b_d;
  logic signed [C_W-1:0]       c_q, c_d;
  logic                        neg_q, neg_d;
  logic                        best_vld_q, best_vld_d;
  logic signed [NUM_W-1:0]     best_num_q, best_num_d;
  color_t                      best_col_q, best_col_d;

  sphere_t                     cur;
  logic signed [CW-1:0]        sx, sy, sz;
  logic signed [A_W-1:0]       dx_a, dy_a, dz_a, a_calc;
  logic signed [B_W-1:0]       dx_b, dy_b, dz_b, sx_b, sy_b, sz_b, dot_b;
  logic signed [C_W-1:0]       sx_c, sy_c, sz_c, r_c, c_calc;
  logic signed [DIS_W-1:0]     a_w, b_w, c_w, dis;
  logic signed [NUM_W-1:0]     num;
  logic [ROOT_W-1:0]           root;
  logic                        sqrt_start, sqrt_vld, hit;

  assign cur = sph_q[sidx_q];
  assign sx  = cur.x;
  assign sy  = cur.y;
  assign sz  = cur.z;

  // a = d.d
  assign dx_a   = A_W'(x_q);
  assign dy_a   = A_W'(y_q);
  assign dz_a   = A_W'(DZ);
  assign a_calc = dx_a * dx_a + dy_a * dy_a + dz_a * dz_a;

  // b = 2(d.s), c = s.s - r^2
  assign dx_b   = B_W'(x_q);
  assign dy_b   = B_W'(y_q);
  assign dz_b   = B_W'(DZ);
  assign sx_b   = B_W'(sx);
  assign sy_b   = B_W'(sy);
  assign sz_b   = B_W'(sz);
  assign dot_b  = dx_b * sx_b + dy_b * sy_b + dz_b * sz_b;
  assign sx_c   = C_W'(sx);
  assign sy_c   = C_W'(sy);
  assign sz_c   = C_W'(sz);
  assign r_c    = C_W'({1'b0, cur.r});
  assign c_calc = sx_c * sx_c + sy_c * sy_c + sz_c * sz_c - r_c * r_c;

  assign a_w = DIS_W'(a_q);
  assign b_w = DIS_W'(b_q);
  assign c_w = DIS_W'(c_q);
  assign dis = b_w * b_w - ((a_w * c_w) <<< 2);

  // Hit needs a real root and a positive near intersection; num < 0 means behind the eye.
  assign num = NUM_W'(b_q) - NUM_W'({1'b0, root});
  assign hit = !neg_q && !num[NUM_W-1] && (num != '0);

  ray_strip_worker_isqrt #(.W(DIS_W)) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start_i (sqrt_start),
    .op_i    (dis),
    .vld_o   (sqrt_vld),
    .root_o  (root)
  );

  always_comb begin
    state_d    = state_q;
    sph_d      = sph_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_d      = pix_q;
    sidx_d     = sidx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    neg_d      = neg_q;
    best_vld_d = best_vld_q;
    best_num_d = best_num_q;
    best_col_d = best_col_q;
    sqrt_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sph_d      = spheres;
          x_d        = D_W'(pixel_start_x);
          y_d        = D_W'(pixel_y);
          pix_d      = '0;
          sidx_d     = '0;
          best_vld_d = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        a_d     = a_calc;
        state_d = PRODUCTS;
      end
      PRODUCTS: begin
        b_d     = dot_b <<< 1;
        c_d     = c_calc;
        state_d = QUAD;
      end
      QUAD: begin
        neg_d      = dis[DIS_W-1];
        sqrt_start = 1'b1;
        state_d    = SQRT_WAIT;
      end
      SQRT_WAIT: begin
        if (sqrt_vld) state_d = COMPARE;
      end
      COMPARE: begin
        // Strict less-than keeps the lower sphere index on ties.
        if (hit && (!best_vld_q || (num < best_num_q))) begin
          best_vld_d = 1'b1;
          best_num_d = num;
          best_col_d = cur.color;
        end
        if (sidx_q == SIDX_W'(N_SPHERES - 1)) begin
          sidx_d  = '0;
          state_d = WRITE;
        end else begin
          sidx_d  = sidx_q + 1'b1;
          state_d = PRODUCTS;
        end
      end
      WRITE: begin
        best_vld_d = 1'b0;
        if (pix_q == AW'(STRIP_LEN - 1)) begin
          state_d = DONE;
        end else begin
          pix_d   = pix_q + 1'b1;
          x_d     = x_q + D_W'(PX_STRIDE);
          state_d = SETUP;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sph_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pix_q      <= '0;
      sidx_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      neg_q      <= 1'b0;
      best_vld_q <= 1'b0;
      best_num_q <= '0;
      best_col_q <= '0;
    end else begin
      state_q    <= state_d;
      sph_q      <= sph_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_q      <= pix_d;
      sidx_q     <= sidx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      neg_q      <= neg_d;
      best_vld_q <= best_vld_d;
      best_num_q <= best_num_d;
      best_col_q <= best_col_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_en    = (state_q == WRITE);
  assign wr_addr  = pix_q;
  assign wr_color = (state_q != WRITE) ? '0 :
                    (best_vld_q ? best_col_q : BACKGROUND_COLOR);

endmodule

// File: tb/tb_ray_strip_worker.sv
// Directed bench for ray_strip_worker at default parameters (4 spheres, 64 pixels, stride 10).
module tb_ray_strip_worker;
  import ray_strip_worker_pkg::*;

  localparam color_t BG = 24'h203040;
  localparam color_t C1 = 24'hFF0000;
  localparam color_t C2 = 24'h00FF00;
  localparam color_t C3 = 24'h0000FF;
  localparam color_t C4 = 24'h111111;
  localparam color_t C5 = 24'h222222;
  localparam color_t CF = 24'hABCDEF;
  localparam int PIX_LAT = 150;
  localparam int JOB_BUSY = 64 * 150 + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [11:0] pixel_start_x = '0;
  logic signed [11:0] pixel_y = '0;
  sphere_t [3:0]      sph = '0;
  logic               busy, done, wr_en;
  logic [5:0]         wr_addr;
  color_t             wr_color;

  int n_chk = 0;
  int n_fail = 0;

  ray_strip_worker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pixel_start_x (pixel_start_x),
    .pixel_y       (pixel_y),
    .spheres       (sph),
    .busy          (busy),
    .done          (done),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_color      (wr_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic sphere_t mk(input int x, input int y, input int z, input int r, input color_t col);
    sphere_t s;
    s.x = 16'(x);
    s.y = 16'(y);
    s.z = 16'(z);
    s.r = 15'(r);
    s.color = col;
    return s;
  endfunction

  task automatic start_job(input int x, input int y);
    pixel_start_x = 12'(x);
    pixel_y = 12'(y);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle offset (start edge = 0) at which wr_en is seen; 400 means timeout.
  task automatic wait_wr(output int lat);
    lat = 1;
    while (!wr_en && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic pix_test(input string tag, input sphere_t [3:0] s, input color_t exp);
    int lat;
    sph = s;
    start_job(0, 0);
    wait_wr(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(PIX_LAT));
    chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_color"}, 64'(wr_color), 64'(exp));
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sphere_t f;
    int lat, wr_cnt, busy_cnt, cyc;
    logic seen_done;
    f = mk(0, 0, -640, 64, CF);

    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_color", 64'(wr_color), 64'd0);
    rst = 1'b0;
    tick();

    pix_test("hit_front", {f, f, f, mk(0, 0, 640, 64, C1)}, C1);
    pix_test("miss_side", {f, f, f, mk(1000, 0, 640, 64, C1)}, BG);
    pix_test("near_idx1", {f, f, mk(0, 0, 640, 64, C3), mk(0, 0, 1280, 64, C2)}, C3);
    pix_test("near_idx0", {f, f, mk(0, 0, 1280, 64, C2), mk(0, 0, 640, 64, C3)}, C3);
    pix_test("tie_low", {f, f, mk(0, 0, 640, 64, C5), mk(0, 0, 640, 64, C4)}, C4);
    pix_test("behind", {f, f, f, mk(0, 0, -640, 64, C1)}, BG);
    pix_test("hit_idx3", {mk(0, 0, 640, 64, C2), f, f, f}, C2);

    // Full strip: x = -320 + 10k hits the on-axis sphere only for k = 29..35.
    sph = {f, f, f, mk(0, 0, 640, 64, C1)};
    start_job(-320, 0);
    wr_cnt = 0;
    busy_cnt = 0;
    seen_done = 1'b0;
    for (cyc = 1; cyc <= 10000; cyc++) begin
      if (busy) busy_cnt++;
      if (wr_en) begin
        chk("job_addr", 64'(wr_addr), 64'(wr_cnt));
        chk("job_color", 64'(wr_color), ((wr_cnt >= 29) && (wr_cnt <= 35)) ? 64'(C1) : 64'(BG));
        wr_cnt++;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (cyc == 500) begin
        start = 1'b1;
        pixel_start_x = 12'sd0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("job_done_seen", 64'(seen_done), 64'd1);
    chk("job_wr_count", 64'(wr_cnt), 64'd64);
    chk("job_busy_cycles", 64'(busy_cnt), 64'(JOB_BUSY));
    tick();
    chk("job_idle_busy", 64'(busy), 64'd0);
    chk("job_idle_done", 64'(done), 64'd0);

    // Abort during pixel 17's sqrt wait.
    start_job(-320, 0);
    wr_cnt = 0;
    cyc = 0;
    while (wr_cnt < 17 && cyc < 5000) begin
      if (wr_en) wr_cnt++;
      tick();
      cyc++;
    end
    chk("abort_reach17", 64'(wr_cnt), 64'd17);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    wr_cnt = 0;
    repeat (400) begin
      if (wr_en) wr_cnt++;
      tick();
    end
    chk("abort_no_wr", 64'(wr_cnt), 64'd0);
    start_job(-320, 0);
    wait_wr(lat);
    chk("restart_lat", 64'(lat), 64'(PIX_LAT));
    chk("restart_addr", 64'(wr_addr), 64'd0);
    chk("restart_color", 64'(wr_color), 64'(BG));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
